// File: rtl/agc_pkg.sv
// rtl/agc_pkg.sv - shared helpers for the AGC saturate/scale stage
package agc_pkg;

  localparam int MAX_W     = 32;
  localparam int MAX_LANES = 64;

  function automatic bit cfg_legal(input int lsb, input int nbits, input int in_w, input int nsamp);
    return (lsb >= 1) && (nbits >= 3) && (nbits <= MAX_W) &&
           (lsb + nbits <= in_w) && (nsamp >= 1) && (nsamp <= MAX_LANES);
  endfunction

  // Offset-binary code from the rounded in-range value, or a rail when out of range.
  function automatic logic [MAX_W-1:0] sat_code(input logic [MAX_W-1:0] r, input logic inb,
                                                input logic sign, input int nbits);
    logic [MAX_W-1:0] ones;
    ones = (MAX_W'(1) << nbits) - MAX_W'(1);
    if (inb)
      return (r ^ (MAX_W'(1) << (nbits - 1))) & ones;
    else if (sign)
      return '0;
    else
      return ones;
  endfunction

  // Symmetric magnitude: the most negative code folds onto the largest positive one.
  function automatic logic [MAX_W-1:0] sym_abs(input logic [MAX_W-1:0] r, input logic inb,
                                               input int nbits);
    logic [MAX_W-1:0] half;
    logic [MAX_W-1:0] mag;
    half = MAX_W'(1) << (nbits - 1);
    if (!inb)
      return half - MAX_W'(1);
    if (r[nbits-1]) begin
      mag = ((~r) + MAX_W'(1)) & ((half << 1) - MAX_W'(1));
      if (mag == half)
        mag = half - MAX_W'(1);
    end else begin
      mag = r;
    end
    return mag;
  endfunction

  function automatic int popcount(input logic [MAX_LANES-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_LANES; i++)
      n += int'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/saturate_scale_lane.sv
// rtl/saturate_scale_lane.sv - one lane: range check/round (S1), code/abs/flags (S2)
module saturate_scale_lane
  import agc_pkg::*;
#(
  parameter int IN_W  = 48,
  parameter int LSB   = 4,
  parameter int NBITS = 5
) (
  input  logic             clk_i,
  input  logic             aresetn_i,
  input  logic [IN_W-1:0]  in_i,
  input  logic [NBITS-2:0] thresh_i,
  output logic [NBITS-1:0] out_o,
  output logic [NBITS-2:0] abs_o,
  output logic             gt_o,
  output logic             lt_o
);

  localparam int HI_W = IN_W - LSB - NBITS + 1;
  localparam int AW   = NBITS - 1;

  logic [HI_W-1:0]  hi;
  logic [NBITS-1:0] b;
  logic [NBITS-1:0] r_d, r_q;
  logic             inb_d, inb_q, sign_q;
  logic [NBITS-1:0] code_d, code_q;
  logic [AW-1:0]    abs_d, abs_q;
  logic             big, gt_d, lt_d, gt_q, lt_q;

  assign hi    = in_i[IN_W-1 -: HI_W];
  assign inb_d = (hi == '0) || (hi == '1);
  assign b     = in_i[LSB +: NBITS];
  // Sticky round: OR the guard bit into the LSB so no carry chain is needed.
  assign r_d   = {b[NBITS-1:1], b[0] | in_i[LSB-1]};

  if (LSB >= 2) begin : g_lsbs
    logic unused_lsbs;
    assign unused_lsbs = ^in_i[LSB-2:0];
  end

  assign code_d = NBITS'(sat_code(MAX_W'(r_q), inb_q, sign_q, NBITS));
  assign abs_d  = AW'(sym_abs(MAX_W'(r_q), inb_q, NBITS));
  assign big    = (abs_d > thresh_i) || !inb_q;
  assign gt_d   = !sign_q && big;
  assign lt_d   = sign_q && big;

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      r_q    <= '0;
      inb_q  <= 1'b0;
      sign_q <= 1'b0;
      code_q <= '0;
      abs_q  <= '0;
      gt_q   <= 1'b0;
      lt_q   <= 1'b0;
    end else begin
      r_q    <= r_d;
      inb_q  <= inb_d;
      sign_q <= in_i[IN_W-1];
      code_q <= code_d;
      abs_q  <= abs_d;
      gt_q   <= gt_d;
      lt_q   <= lt_d;
    end
  end

  assign out_o = code_q;
  assign abs_o = abs_q;
  assign gt_o  = gt_q;
  assign lt_o  = lt_q;

endmodule

// File: rtl/saturate_scale_multi.sv
// rtl/saturate_scale_multi.sv - multi-lane saturate/round/scale with windowed GT/LT totals
module saturate_scale_multi
  import agc_pkg::*;
#(
  parameter int NSAMP = 8,
  parameter int IN_W  = 48,
  parameter int LSB   = 4,
  parameter int NBITS = 5,
  parameter int CNT_W = 24
) (
  input  logic                       clk_i,
  input  logic                       aresetn_i,
  input  logic [NSAMP*IN_W-1:0]      in_i,
  input  logic                       in_valid_i,
  input  logic [NBITS-2:0]           thresh_i,
  input  logic [CNT_W-1:0]           win_len_i,
  output logic [NSAMP*NBITS-1:0]     out_o,
  output logic [NSAMP*(NBITS-1)-1:0] abs_o,
  output logic [NSAMP-1:0]           gt_o,
  output logic [NSAMP-1:0]           lt_o,
  output logic                       out_valid_o,
  output logic [CNT_W-1:0]           gt_count_o,
  output logic [CNT_W-1:0]           lt_count_o,
  output logic                       count_valid_o,
  input  logic                       count_ack_i,
  output logic                       overrun_o
);

  localparam int PC_W  = $clog2(NSAMP + 1);
  localparam int SUM_W = CNT_W + 1;

  if (!cfg_legal(LSB, NBITS, IN_W, NSAMP)) begin : g_bad_cfg
    $error("saturate_scale_multi: illegal LSB/NBITS/IN_W/NSAMP combination");
  end

  for (genvar k = 0; k < NSAMP; k++) begin : g_lane
    saturate_scale_lane #(
      .IN_W  (IN_W),
      .LSB   (LSB),
      .NBITS (NBITS)
    ) u_lane (
      .clk_i     (clk_i),
      .aresetn_i (aresetn_i),
      .in_i      (in_i[k*IN_W +: IN_W]),
      .thresh_i  (thresh_i),
      .out_o     (out_o[k*NBITS +: NBITS]),
      .abs_o     (abs_o[k*(NBITS-1) +: (NBITS-1)]),
      .gt_o      (gt_o[k]),
      .lt_o      (lt_o[k])
    );
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [PC_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = {1'b0, a} + SUM_W'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  logic [1:0]       vld_q;
  logic [CNT_W-1:0] acc_gt_q, acc_gt_d, acc_lt_q, acc_lt_d, wcnt_q, wcnt_d;
  logic [CNT_W-1:0] gt_cnt_q, gt_cnt_d, lt_cnt_q, lt_cnt_d;
  logic             cv_q, cv_d, ovr_q, ovr_d;
  logic [PC_W-1:0]  pc_gt, pc_lt;
  logic [CNT_W-1:0] gt_sum, lt_sum;
  logic             win_en, beat, close, ack_take;

  assign out_valid_o = vld_q[1];
  assign pc_gt  = PC_W'(popcount(MAX_LANES'(gt_o)));
  assign pc_lt  = PC_W'(popcount(MAX_LANES'(lt_o)));
  assign gt_sum = sat_add(acc_gt_q, pc_gt);
  assign lt_sum = sat_add(acc_lt_q, pc_lt);
  assign win_en = (win_len_i != '0);
  assign beat   = out_valid_o && win_en;
  // >= rather than == so a window shrunk below the current count closes immediately.
  assign close    = beat && (({1'b0, wcnt_q} + SUM_W'(1)) >= {1'b0, win_len_i});
  assign ack_take = count_ack_i && cv_q;

  always_comb begin
    acc_gt_d = acc_gt_q;
    acc_lt_d = acc_lt_q;
    wcnt_d   = wcnt_q;
    gt_cnt_d = gt_cnt_q;
    lt_cnt_d = lt_cnt_q;
    cv_d     = cv_q;
    ovr_d    = ovr_q;

    if (!win_en) begin
      acc_gt_d = '0;
      acc_lt_d = '0;
      wcnt_d   = '0;
    end else if (close) begin
      acc_gt_d = '0;
      acc_lt_d = '0;
      wcnt_d   = '0;
    end else if (beat) begin
      acc_gt_d = gt_sum;
      acc_lt_d = lt_sum;
      wcnt_d   = wcnt_q + CNT_W'(1);
    end

    if (ack_take) begin
      cv_d  = 1'b0;
      ovr_d = 1'b0;
    end

    if (close) begin
      if (!cv_q || count_ack_i) begin
        gt_cnt_d = gt_sum;
        lt_cnt_d = lt_sum;
        cv_d     = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      vld_q    <= '0;
      acc_gt_q <= '0;
      acc_lt_q <= '0;
      wcnt_q   <= '0;
      gt_cnt_q <= '0;
      lt_cnt_q <= '0;
      cv_q     <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      vld_q    <= {vld_q[0], in_valid_i};
      acc_gt_q <= acc_gt_d;
      acc_lt_q <= acc_lt_d;
      wcnt_q   <= wcnt_d;
      gt_cnt_q <= gt_cnt_d;
      lt_cnt_q <= lt_cnt_d;
      cv_q     <= cv_d;
      ovr_q    <= ovr_d;
    end
  end

  assign gt_count_o    = gt_cnt_q;
  assign lt_count_o    = lt_cnt_q;
  assign count_valid_o = cv_q;
  assign overrun_o     = ovr_q;

endmodule

// File: tb/tb_saturate_scale_multi.sv
// tb/tb_saturate_scale_multi.sv - directed scoreboard bench for saturate_scale_multi
module tb_saturate_scale_multi;

  localparam int NSAMP = 8;
  localparam int IN_W  = 48;
  localparam int LSB   = 4;
  localparam int NBITS = 5;
  localparam int CNT_W = 24;

  logic                       clk;
  logic                       rst_n;
  logic [NSAMP*IN_W-1:0]      in_i;
  logic                       in_valid;
  logic [NBITS-2:0]           thresh;
  logic [CNT_W-1:0]           win_len;
  logic [NSAMP*NBITS-1:0]     out_o;
  logic [NSAMP*(NBITS-1)-1:0] abs_o;
  logic [NSAMP-1:0]           gt_o, lt_o;
  logic                       out_valid;
  logic [CNT_W-1:0]           gt_count, lt_count;
  logic                       count_valid, count_ack, overrun;

  saturate_scale_multi #(
    .NSAMP(NSAMP), .IN_W(IN_W), .LSB(LSB), .NBITS(NBITS), .CNT_W(CNT_W)
  ) dut (
    .clk_i         (clk),
    .aresetn_i     (rst_n),
    .in_i          (in_i),
    .in_valid_i    (in_valid),
    .thresh_i      (thresh),
    .win_len_i     (win_len),
    .out_o         (out_o),
    .abs_o         (abs_o),
    .gt_o          (gt_o),
    .lt_o          (lt_o),
    .out_valid_o   (out_valid),
    .gt_count_o    (gt_count),
    .lt_count_o    (lt_count),
    .count_valid_o (count_valid),
    .count_ack_i   (count_ack),
    .overrun_o     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NSAMP*NBITS-1:0]     code;
    logic [NSAMP*(NBITS-1)-1:0] mag;
    logic [NSAMP-1:0]           gt;
    logic [NSAMP-1:0]           lt;
  } exp_t;

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: floor-divide by 16, clamp to the 5-bit signed range, then sticky-round.
  task automatic model(input logic [IN_W-1:0] x, input logic [3:0] th,
                       output logic [4:0] code, output logic [3:0] mag,
                       output logic g, output logic l);
    longint v, q;
    v = longint'($signed(x));
    q = v >>> 4;
    if (q > 15) begin
      code = 5'd31; mag = 4'd15; g = 1'b1; l = 1'b0;
    end else if (q < -16) begin
      code = 5'd0;  mag = 4'd15; g = 1'b0; l = 1'b1;
    end else begin
      if (x[3]) q = q | 64'sd1;
      code = 5'(q + 16);
      if (q == -16)    mag = 4'd15;
      else if (q < 0)  mag = 4'(-q);
      else             mag = 4'(q);
      g = (q >= 0) && (mag > th);
      l = (q < 0) && (mag > th);
    end
  endtask

  task automatic step(input logic v, input logic [IN_W-1:0] lanes [NSAMP]);
    exp_t e;
    logic [4:0] c;
    logic [3:0] m;
    logic       g, l;
    in_valid = v;
    for (int k = 0; k < NSAMP; k++) begin
      in_i[k*IN_W +: IN_W] = lanes[k];
      model(lanes[k], thresh, c, m, g, l);
      e.code[k*NBITS +: NBITS]         = c;
      e.mag[k*(NBITS-1) +: (NBITS-1)]  = m;
      e.gt[k] = g;
      e.lt[k] = l;
    end
    if (v) sb.push_back(e);
    @(posedge clk);
    #1;
    if (out_valid) begin
      vectors++;
      assert (sb.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_beat: observed out_valid 1 expected 0");
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out_code", 64'(out_o), 64'(e.code));
        check("abs",      64'(abs_o), 64'(e.mag));
        check("gt",       64'(gt_o),  64'(e.gt));
        check("lt",       64'(lt_o),  64'(e.lt));
      end
    end
  endtask

  task automatic step_all(input logic v, input longint x);
    logic [IN_W-1:0] lanes [NSAMP];
    for (int k = 0; k < NSAMP; k++) lanes[k] = IN_W'(x);
    step(v, lanes);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step_all(1'b0, 0);
  endtask

  initial begin
    logic [IN_W-1:0] lanes [NSAMP];
    vectors     = 0;
    miscompares = 0;
    rst_n     = 1'b0;
    in_i      = '0;
    in_valid  = 1'b0;
    thresh    = 4'd7;
    win_len   = '0;
    count_ack = 1'b0;

    #12;
    check("rst_out",     64'(out_o), 64'd0);
    check("rst_abs",     64'(abs_o), 64'd0);
    check("rst_flags",   64'({gt_o, lt_o, out_valid}), 64'd0);
    check("rst_counts",  64'({gt_count, lt_count, count_valid, overrun}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Per-lane behaviour around rounding and saturation boundaries.
    step_all(1'b1, 72);
    step_all(1'b1, 64);
    step_all(1'b1, -72);
    step_all(1'b1, 128);
    step_all(1'b1, 112);
    step_all(1'b0, 5000);
    step_all(1'b1, 1000);
    step_all(1'b1, -1000);
    step_all(1'b1, -128);
    step_all(1'b1, -256);
    step_all(1'b1, 255);
    step_all(1'b1, -257);
    idle(3);
    check("drain_a", 64'(sb.size()), 64'd0);

    for (int n = 0; n < 12; n++) begin
      for (int k = 0; k < NSAMP; k++)
        lanes[k] = IN_W'(longint'($urandom_range(0, 700)) - 350);
      step($urandom_range(0, 1) == 1, lanes);
    end
    idle(3);

    thresh = 4'd15;
    step_all(1'b1, 1000);
    step_all(1'b1, -1000);
    step_all(1'b1, 200);
    idle(3);
    check("drain_b", 64'(sb.size()), 64'd0);
    thresh = 4'd7;
    idle(1);

    // Window of 4 valid beats with bubbles.
    win_len = 24'd4;
    step_all(1'b1, 1000);
    step_all(1'b1, 1000);
    step_all(1'b0, 1000);
    step_all(1'b1, 1000);
    step_all(1'b0, 1000);
    step_all(1'b1, 1000);
    idle(3);
    check("w1_cv",  64'(count_valid), 64'd1);
    check("w1_gt",  64'(gt_count),    64'd32);
    check("w1_lt",  64'(lt_count),    64'd0);
    check("w1_ovr", 64'(overrun),     64'd0);

    // Unread counts: the next window is discarded.
    for (int i = 0; i < 4; i++) step_all(1'b1, 1000);
    idle(3);
    check("w2_ovr", 64'(overrun),     64'd1);
    check("w2_cv",  64'(count_valid), 64'd1);
    check("w2_gt",  64'(gt_count),    64'd32);

    // Ack coincident with the closing beat reloads and clears overrun.
    for (int i = 0; i < 4; i++) step_all(1'b1, 1000);
    idle(1);
    count_ack = 1'b1;
    idle(1);
    count_ack = 1'b0;
    check("w3_cv",  64'(count_valid), 64'd1);
    check("w3_ovr", 64'(overrun),     64'd0);
    check("w3_gt",  64'(gt_count),    64'd32);
    idle(2);

    count_ack = 1'b1;
    idle(1);
    count_ack = 1'b0;
    check("ack_cv",  64'(count_valid), 64'd0);
    check("ack_hold", 64'(gt_count),   64'd32);
    count_ack = 1'b1;
    idle(1);
    count_ack = 1'b0;
    check("ack_low_cv", 64'(count_valid), 64'd0);

    for (int i = 0; i < 4; i++) step_all(1'b1, -1000);
    idle(3);
    check("w4_cv", 64'(count_valid), 64'd1);
    check("w4_lt", 64'(lt_count),    64'd32);
    check("w4_gt", 64'(gt_count),    64'd0);

    // Reset with two beats already in the window.
    step_all(1'b1, 1000);
    step_all(1'b1, 1000);
    idle(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_counts", 64'({gt_count, lt_count}), 64'd0);
    check("mid_rst_flags",  64'({count_valid, overrun, out_valid}), 64'd0);
    check("mid_rst_out",    64'(out_o), 64'd0);
    sb.delete();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) step_all(1'b1, -1000);
    idle(3);
    check("w5_cv",  64'(count_valid), 64'd1);
    check("w5_lt",  64'(lt_count),    64'd32);
    check("w5_ovr", 64'(overrun),     64'd0);

    // Counting disabled: nothing closes.
    win_len   = '0;
    count_ack = 1'b1;
    idle(1);
    count_ack = 1'b0;
    for (int i = 0; i < 6; i++) step_all(1'b1, 1000);
    idle(3);
    check("dis_cv", 64'(count_valid), 64'd0);
    check("dis_lt", 64'(lt_count),    64'd32);
    check("drain_c", 64'(sb.size()),  64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
